// File: rtl/lenet_pkg.sv
// lenet_pkg: shared constants and types for the LeNet datapath.
//   DATA_W        sample width of the conv / pool stages
//   CONV_OUT_DIM  side of the feature map produced by conv_2d
//   POOL_OUT_DIM  side of the map produced by maxpool_2x2
//   sample_t      signed sample type
package lenet_pkg;
  localparam int DATA_W       = 16;
  localparam int CONV_OUT_DIM = 24;
  localparam int POOL_OUT_DIM = CONV_OUT_DIM / 2;

  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/pool_linebuf.sv
// pool_linebuf: one-row buffer of horizontal maxima for the 2x2 max-pool.
// One write port, one combinational read port, no reset (every entry is
// written on an even row before the following odd row reads it).
//   clk    clock, writes on rising edge
//   we     write enable
//   waddr  write address (0..DEPTH-1)
//   wdata  write data
//   raddr  read address (0..DEPTH-1)
//   rdata  read data, combinational
module pool_linebuf #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 max-pool with optional fused ReLU.
// Consumes an IN_DIM x IN_DIM raster-order map of signed samples and emits
// the (IN_DIM/2) x (IN_DIM/2) pooled map in raster order.
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept an input beat
//   in_data    signed conv result, row-major
//   out_valid  pooled result present
//   out_ready  downstream accepts the pooled result
//   out_data   signed pooled result
//   out_last   marks the final pooled result of a frame
module maxpool_2x2 #(
  parameter int IN_DIM = lenet_pkg::CONV_OUT_DIM,
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int RELU   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int CW      = $clog2(IN_DIM);
  localparam int AW      = CW - 1;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] x
  );
    if ((RELU != 0) && (x < 0)) return '0;
    return x;
  endfunction

  logic [CW-1:0]            row_p0;
  logic [CW-1:0]            col_p0;
  logic signed [DATA_W-1:0] hold_p0;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] pmax;
  logic signed [DATA_W-1:0] pooled;
  logic [DATA_W-1:0]        lb_rd;
  logic [AW-1:0]            lb_addr;
  logic                     accept;
  logic                     row_last;
  logic                     col_last;
  logic                     lb_we;
  logic                     load;

  // Stall on every beat while a result is stuck, not only on producing beats.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign row_last = (row_p0 == CW'(IN_DIM - 1));
  assign col_last = (col_p0 == CW'(IN_DIM - 1));
  assign lb_addr  = col_p0[CW-1:1];

  assign din    = $signed(in_data);
  assign hmax   = smax(hold_p0, din);
  assign pmax   = smax($signed(lb_rd), hmax);
  assign pooled = relu_clamp(pmax);

  // Even rows park their horizontal max; odd rows combine and emit.
  assign lb_we = accept && col_p0[0] && !row_p0[0];
  assign load  = accept && col_p0[0] && row_p0[0];

  pool_linebuf #(
    .DEPTH  (OUT_DIM),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rd)
  );

  // Stage p0: position counters and even-column hold register
  always_ff @(posedge clk) begin
    if (rst) begin
      row_p0  <= '0;
      col_p0  <= '0;
      hold_p0 <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_p0 <= '0;
        row_p0 <= row_last ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
      if (!col_p0[0]) hold_p0 <= din;
    end
  end

  // Output register: a load wins over a simultaneous drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
      out_last  <= row_last && col_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

  localparam int D  = lenet_pkg::CONV_OUT_DIM;
  localparam int PD = lenet_pkg::POOL_OUT_DIM;
  localparam int W  = lenet_pkg::DATA_W;

  typedef struct packed {
    logic signed [W-1:0] d;
    logic                last;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         in_ready_r, out_valid_r, out_last_r;
  logic [W-1:0] out_data_r;
  logic         in_ready_p, out_valid_p, out_last_p;
  logic [W-1:0] out_data_p;

  maxpool_2x2 #(.IN_DIM(D), .DATA_W(W), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .out_last(out_last_r)
  );

  maxpool_2x2 #(.IN_DIM(D), .DATA_W(W), .RELU(0)) u_pass (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p),
    .in_data(in_data), .out_valid(out_valid_p), .out_ready(out_ready),
    .out_data(out_data_p), .out_last(out_last_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_r[$];
  exp_t exp_p[$];
  int   n_out_r  = 0;
  int   img[D][D];
  int   rdy_mode = 0;
  int   bp_at    = -1;
  bit   bp_done  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Reference: pooled value is the max of the 2x2 window ending at (r,c).
  task automatic push_expected(input int r, input int c);
    int   m;
    exp_t e;
    m = img[r-1][c-1];
    if (img[r-1][c] > m) m = img[r-1][c];
    if (img[r][c-1] > m) m = img[r][c-1];
    if (img[r][c] > m) m = img[r][c];
    e.last = (r == D-1) && (c == D-1);
    e.d = W'(m);
    exp_p.push_back(e);
    e.d = W'((m < 0) ? 0 : m);
    exp_r.push_back(e);
  endtask

  task automatic fill_frame(input int kind);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < D; c++)
        case (kind)
          0: img[r][c] = r * D + c;
          1: img[r][c] = (r == 0 && c == 0) ? -1 : -5;
          2: img[r][c] = int'($urandom_range(0, 65535)) - 32768;
          default: img[r][c] = 0;
        endcase
    if (kind == 3) begin
      for (int i = 0; i < PD; i++)
        for (int j = 0; j < PD; j++) begin
          int p;
          p = (i * PD + j) % 4;
          for (int q = 0; q < 4; q++) begin
            int v;
            if (q == p) v = 32767;
            else if (q == (p + 1) % 4) v = -32768;
            else v = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            img[2*i + q/2][2*j + q%2] = v;
          end
        end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_frame(input int kind, input int nbeats, input int gap_pct);
    fill_frame(kind);
    for (int b = 0; b < nbeats; b++) begin
      int r, c, w;
      bit ok;
      r = b / D;
      c = b % D;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      if (r[0] && c[0]) push_expected(r, c);
      in_valid = 1'b1;
      in_data  = W'(img[r][c]);
      w  = 0;
      ok = 1'b0;
      while (!ok && w < 1000) begin
        @(negedge clk);
        ok = in_ready_r;
        @(posedge clk);
        #1;
        w++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_r.size() != 0 || exp_p.size() != 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_pending", exp_r.size() + exp_p.size(), 0);
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_r), 0);
    chk("rst_out_data", int'(out_data_r), 0);
    chk("rst_out_last", int'(out_last_r), 0);
    chk("rst_in_ready", int'(in_ready_r), 1);
    chk("rst_out_valid_p", int'(out_valid_p), 0);
    @(posedge clk);
    #1;
  endtask

  // Output handshake driver, changes only just after the rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = ($urandom_range(0, 99) < 60);
        2: begin
          out_ready = 1'b1;
          if (!bp_done && out_valid_r && n_out_r == bp_at) begin
            logic [W-1:0] held_r, held_p;
            logic         last_r;
            held_r = out_data_r;
            held_p = out_data_p;
            last_r = out_last_r;
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
              @(negedge clk);
              chk("bp_in_ready", int'(in_ready_r), 0);
              chk("bp_out_valid", int'(out_valid_r), 1);
              chk("bp_hold_data", int'(out_data_r), int'(held_r));
              chk("bp_hold_data_p", int'(out_data_p), int'(held_p));
              chk("bp_hold_last", int'(out_last_r), int'(last_r));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            bp_done = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid_r) begin
        if (exp_r.size() == 0) chk("relu_unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = exp_r.pop_front();
          chk("relu_data", int'($signed(out_data_r)), int'(e.d));
          chk("relu_last", int'(out_last_r), int'(e.last));
          n_out_r++;
        end
      end
      if (out_valid_p) begin
        if (exp_p.size() == 0) chk("pass_unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = exp_p.pop_front();
          chk("pass_data", int'($signed(out_data_p)), int'(e.d));
          chk("pass_last", int'(out_last_p), int'(e.last));
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // Ramp frame, continuous flow
    rdy_mode = 0;
    send_frame(0, D*D, 0);
    drain();

    // All-negative frame
    send_frame(1, D*D, 0);
    drain();

    // Backpressure on result 5 of a ramp frame
    bp_at    = n_out_r + 5;
    bp_done  = 1'b0;
    rdy_mode = 2;
    send_frame(0, D*D, 0);
    drain();
    chk("bp_happened", int'(bp_done), 1);

    // Two back-to-back random frames with gaps and random out_ready
    rdy_mode = 1;
    send_frame(2, D*D, 20);
    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    send_frame(2, D*D, 20);
    rdy_mode = 0;
    drain();

    // Reset after 100 accepted beats, then a full ramp frame
    send_frame(0, 100, 0);
    drain();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    check_reset();
    send_frame(0, D*D, 0);
    drain();

    // Extreme values
    send_frame(3, D*D, 10);
    drain();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
